// File: rtl/alu_writeback.sv
// alu_writeback: 2-entry result buffer draining to a register-file or data-memory write port.
// Optional macro WB_FLAGS_EN enables the registered {negative, zero} flags.
module alu_writeback #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] alu_result,
  input  logic [2:0] rd_addr,
  input  logic [7:0] literalOrAddress,
  input  logic [1:0] instructionType,
  input  logic       res_valid,
  output logic       res_ready,
  output logic       rf_we,
  output logic [2:0] rf_waddr,
  output logic [7:0] rf_wdata,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  output logic       wb_busy,
  output logic       timeout_err,
  output logic [1:0] flags
);
  typedef enum logic [1:0] {IDLE, REG_WR, MEM_REQ} state_t;
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);
  state_t state, state_nx;
  logic [20:0] fifo [2];
  logic [20:0] head;
  logic [1:0] count;
  logic [7:0] wait_cnt;
  logic wr_ptr, rd_ptr, push, pop, tmo_hit, rf_we_nx, mem_req_nx;
  assign head = fifo[rd_ptr];
  assign res_ready = count < 2'd2;
  assign push = res_valid && res_ready;
  assign pop = state == IDLE && count != 2'd0;
  assign tmo_hit = wait_cnt == TMO_LAST;
  assign wb_busy = state != IDLE || count != 2'd0;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && pop)
      state_nx = head[1] ? IDLE : head[0] ? REG_WR : MEM_REQ;
    else if (state == REG_WR)
      state_nx = IDLE;
    else if (state == MEM_REQ && (mem_ack || tmo_hit))
      state_nx = IDLE;
  end
  always_comb begin
    rf_we_nx = state_nx == REG_WR;
    mem_req_nx = state_nx == MEM_REQ;
  end
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= {alu_result, rd_addr, literalOrAddress, instructionType};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      wait_cnt <= '0;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      timeout_err <= 1'b0;
    end else begin
      count <= count + 2'(push) - 2'(pop);
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      wait_cnt <= state == MEM_REQ ? wait_cnt + 8'd1 : 8'd0;
      rf_we <= rf_we_nx;
      mem_req <= mem_req_nx;
      if (pop && rf_we_nx) begin
        rf_waddr <= head[12:10];
        rf_wdata <= head[20:13];
      end
      if (pop && mem_req_nx) begin
        mem_addr <= head[9:2];
        mem_wdata <= head[20:13];
      end
      // ack arriving on the last allowed cycle still counts as success
      if (state == MEM_REQ && !mem_ack && tmo_hit) timeout_err <= 1'b1;
    end
  end
`ifdef WB_FLAGS_EN
  always_ff @(posedge clk)
    if (!rst_n) flags <= 2'b00;
    else if (state == REG_WR) flags <= {rf_wdata[7], rf_wdata == 8'd0};
`else
  assign flags = 2'b00;
`endif
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed and randomized checks of alu_writeback against a queue-based model.
module tb_alu_writeback;
  localparam int TMO = 15;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] alu_result = '0, literalOrAddress = '0;
  logic [2:0] rd_addr = '0;
  logic [1:0] instructionType = '0;
  logic res_valid = 1'b0, mem_ack = 1'b0;
  logic res_ready, rf_we, mem_req, wb_busy, timeout_err;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata, mem_addr, mem_wdata;
  logic [1:0] flags;
  int checks = 0, errors = 0;

  alu_writeback #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .alu_result(alu_result), .rd_addr(rd_addr),
    .literalOrAddress(literalOrAddress), .instructionType(instructionType),
    .res_valid(res_valid), .res_ready(res_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .wb_busy(wb_busy), .timeout_err(timeout_err), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] res; logic [2:0] rd; logic [7:0] addr; logic [1:0] typ;} entry_t;
  entry_t q[$];
  int job, age;
  logic m_terr;
  logic [2:0] m_waddr;
  logic [7:0] m_wdata, m_maddr, m_mdata;
  logic [1:0] m_flags;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    job = 0;
    age = 0;
    m_terr = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_maddr = '0;
    m_mdata = '0;
    m_flags = '0;
  endtask

  // job: 0 idle, 1 register write in progress, 2 memory request in progress
  task automatic model_step();
    entry_t e;
    bit accept;
    if (!rst_n) begin
      model_reset();
      return;
    end
    accept = res_valid && q.size() < 2;
    if (job == 0 && q.size() > 0) begin
      e = q.pop_front();
      if (!e.typ[1] && e.typ[0]) begin
        job = 1;
        m_waddr = e.rd;
        m_wdata = e.res;
      end else if (!e.typ[1]) begin
        job = 2;
        age = 0;
        m_maddr = e.addr;
        m_mdata = e.res;
      end
    end else if (job == 1) begin
`ifdef WB_FLAGS_EN
      m_flags = {m_wdata[7], m_wdata == 8'd0};
`endif
      job = 0;
    end else if (job == 2) begin
      age++;
      if (mem_ack) job = 0;
      else if (age == TMO) begin
        m_terr = 1'b1;
        job = 0;
      end
    end
    if (accept) q.push_back('{alu_result, rd_addr, literalOrAddress, instructionType});
  endtask

  task automatic compare_all();
    check("res_ready", res_ready, q.size() < 2);
    check("wb_busy", wb_busy, job != 0 || q.size() != 0);
    check("rf_we", rf_we, job == 1);
    check("rf_waddr", rf_waddr, m_waddr);
    check("rf_wdata", rf_wdata, m_wdata);
    check("mem_req", mem_req, job == 2);
    check("mem_addr", mem_addr, m_maddr);
    check("mem_wdata", mem_wdata, m_mdata);
    check("timeout_err", timeout_err, m_terr);
    check("flags", flags, m_flags);
    check("exclusive", rf_we && mem_req, 1'b0);
  endtask

  task automatic cycle(input logic v, input logic [7:0] r, input logic [2:0] d,
                       input logic [7:0] a, input logic [1:0] t, input logic ack, input logic rn);
    @(negedge clk);
    compare_all();
    res_valid = v;
    alu_result = r;
    rd_addr = d;
    literalOrAddress = a;
    instructionType = t;
    mem_ack = ack;
    rst_n = rn;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle(input int n, input logic ack);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 3'd0, 8'h00, 2'b00, ack, 1'b1);
  endtask

  initial begin
    model_reset();
    cycle(1'b0, 8'h00, 3'd0, 8'h00, 2'b00, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 3'd0, 8'h00, 2'b00, 1'b0, 1'b0);
    check("reset_ready", res_ready, 1'b1);
    check("reset_busy", wb_busy, 1'b0);
    idle(1, 1'b0);
    // register write lands two edges after the push
    cycle(1'b1, 8'h5A, 3'd3, 8'h00, 2'b01, 1'b0, 1'b1);
    check("reg_lat_we0", rf_we, 1'b0);
    idle(1, 1'b0);
    check("reg_we", rf_we, 1'b1);
    check("reg_addr", rf_waddr, 3'd3);
    check("reg_data", rf_wdata, 8'h5A);
    idle(1, 1'b0);
    check("reg_we_once", rf_we, 1'b0);
    idle(2, 1'b0);
    // memory write acknowledged after three request cycles
    cycle(1'b1, 8'h11, 3'd0, 8'h40, 2'b00, 1'b0, 1'b1);
    idle(3, 1'b0);
    check("mem_req_held", mem_req, 1'b1);
    check("mem_addr", mem_addr, 8'h40);
    check("mem_data", mem_wdata, 8'h11);
    cycle(1'b0, 8'h00, 3'd0, 8'h00, 2'b00, 1'b1, 1'b1);
    check("mem_req_done", mem_req, 1'b0);
    idle(2, 1'b0);
    // timeout boundary: still requesting after 14 elapsed cycles, dropped after 15
    cycle(1'b1, 8'h22, 3'd0, 8'h41, 2'b00, 1'b0, 1'b1);
    idle(15, 1'b0);
    check("tmo_not_yet", mem_req, 1'b1);
    check("tmo_err_not_yet", timeout_err, 1'b0);
    idle(1, 1'b0);
    check("tmo_drop", mem_req, 1'b0);
    check("tmo_err", timeout_err, 1'b1);
    idle(5, 1'b1);
    check("tmo_sticky", timeout_err, 1'b1);
    // backpressure with three memory writes and no ack
    cycle(1'b1, 8'hA1, 3'd0, 8'h10, 2'b00, 1'b0, 1'b1);
    cycle(1'b1, 8'hA2, 3'd0, 8'h11, 2'b00, 1'b0, 1'b1);
    cycle(1'b1, 8'hA3, 3'd0, 8'h12, 2'b00, 1'b0, 1'b1);
    check("bp_ready_low", res_ready, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'hA3, 3'd0, 8'h12, 2'b00, (i % 4) == 3, 1'b1);
    idle(4, 1'b1);
    // discard entry and flags
    cycle(1'b1, 8'h77, 3'd5, 8'h33, 2'b10, 1'b0, 1'b1);
    idle(3, 1'b0);
    cycle(1'b1, 8'h00, 3'd1, 8'h00, 2'b01, 1'b0, 1'b1);
    idle(3, 1'b0);
`ifdef WB_FLAGS_EN
    check("flags_zero", flags, 2'b01);
`endif
    cycle(1'b1, 8'h80, 3'd2, 8'h00, 2'b01, 1'b0, 1'b1);
    idle(3, 1'b0);
`ifdef WB_FLAGS_EN
    check("flags_neg", flags, 2'b10);
`endif
    cycle(1'b1, 8'h00, 3'd0, 8'h00, 2'b00, 1'b0, 1'b0);
    check("rst_clears_err", timeout_err, 1'b0);
    idle(1, 1'b0);
    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 2) != 0, 8'($urandom), 3'($urandom), 8'($urandom),
            2'($urandom), $urandom_range(0, 9) < 2, $urandom_range(0, 299) != 0);
    idle(20, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
